// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frame sequencer for the 2^N-point FFT core.
// Captures one frame of real samples into the core, starts it, waits for
// completion and streams the first half-spectrum bins to the consumer.
//
// Handshake rule used on both streaming sides: a transfer happens on a rising
// edge where valid and ready are both high; the producer holds valid and its
// payload unchanged until that edge, and ready never depends on valid.
module fft_frame_ctrl #(
    parameter int BIT_WIDTH = 16,
    parameter int N         = 9,
    parameter int TIMEOUT   = 65535
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   smp_valid,
    input  logic [BIT_WIDTH-1:0]   smp_data,
    output logic                   smp_ready,
    output logic                   fft_load,
    output logic                   fft_start,
    output logic [N-1:0]           add_rd,
    output logic [BIT_WIDTH-1:0]   din,
    input  logic [2*BIT_WIDTH-1:0] fft_dout,
    input  logic                   fft_done,
    output logic                   bin_valid,
    output logic [2*BIT_WIDTH-1:0] bin_data,
    output logic [N-2:0]           bin_idx,
    output logic                   bin_last,
    input  logic                   bin_ready,
    output logic                   busy,
    output logic                   overrun,
    output logic                   timeout_err,
    output logic [2:0]             dbg_state
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [N-1:0]  SMP_LAST = '1;
    localparam logic [N-1:0]  SMP_ONE  = 1;
    localparam logic [N-2:0]  BIN_LAST = '1;
    localparam logic [N-2:0]  BIN_ONE  = 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMR_ONE  = 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_START   = 3'd2,
        S_WAIT    = 3'd3,
        S_RD_ADDR = 3'd4,
        S_RD_PRES = 3'd5
    } state_t;

    state_t          state;
    logic [N-1:0]    smp_cnt;
    logic [N-2:0]    bin_cnt;
    logic [TW-1:0]   timer;
    logic [N-2:0]    bin_next;

    assign bin_next = bin_cnt + BIN_ONE;

    // Status decoded straight from the state register, so glitch-free.
    assign smp_ready = (state == S_LOAD);
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    // The core holds fft_dout while add_rd is held in RD_PRES, so the bin
    // payload can pass through and still stay stable until accepted.
    assign bin_data  = bin_valid ? fft_dout : '0;

    // Frame sequencer: capture, start, wait, then bin readout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            smp_cnt     <= '0;
            bin_cnt     <= '0;
            timer       <= '0;
            fft_load    <= 1'b0;
            fft_start   <= 1'b0;
            add_rd      <= '0;
            din         <= '0;
            bin_valid   <= 1'b0;
            bin_idx     <= '0;
            bin_last    <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // Strobes default low; each state raises them for a single cycle.
            fft_load  <= 1'b0;
            fft_start <= 1'b0;

            // A sample offered while we cannot take it is lost; remember that.
            if (run && smp_valid && !smp_ready) begin
                overrun <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (run) begin
                        smp_cnt <= '0;
                        state   <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    // run is not checked here: a started frame always finishes.
                    if (smp_valid) begin
                        fft_load <= 1'b1;
                        add_rd   <= smp_cnt;
                        din      <= smp_data;
                        smp_cnt  <= smp_cnt + SMP_ONE;
                        if (smp_cnt == SMP_LAST) begin
                            state <= S_START;
                        end
                    end
                end

                S_START: begin
                    fft_start <= 1'b1;
                    timer     <= '0;
                    state     <= S_WAIT;
                end

                S_WAIT: begin
                    // Completion wins over a timeout landing on the same cycle.
                    if (fft_done) begin
                        bin_cnt <= '0;
                        add_rd  <= '0;
                        state   <= S_RD_ADDR;
                    end else if (timer == TMR_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        timer <= timer + TMR_ONE;
                    end
                end

                S_RD_ADDR: begin
                    // add_rd already points at bin_cnt; the core answers next cycle.
                    bin_valid <= 1'b1;
                    bin_idx   <= bin_cnt;
                    bin_last  <= (bin_cnt == BIN_LAST);
                    state     <= S_RD_PRES;
                end

                S_RD_PRES: begin
                    if (bin_ready) begin
                        bin_valid <= 1'b0;
                        bin_last  <= 1'b0;
                        if (!bin_last) begin
                            bin_cnt <= bin_next;
                            add_rd  <= {1'b0, bin_next};
                            state   <= S_RD_ADDR;
                        end else if (run) begin
                            smp_cnt <= '0;
                            state   <= S_LOAD;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: randomized bench for fft_frame_ctrl with a behavioural
// FFT core stand-in and a frame-level expectation model.
module tb_fft_frame_ctrl;

    localparam int BW   = 16;
    localparam int N    = 9;
    localparam int TMO  = 100;
    localparam int NSMP = 1 << N;
    localparam int NBIN = 1 << (N - 1);

    logic            clk;
    logic            reset;
    logic            run;
    logic            smp_valid;
    logic [BW-1:0]   smp_data;
    logic            smp_ready;
    logic            fft_load;
    logic            fft_start;
    logic [N-1:0]    add_rd;
    logic [BW-1:0]   din;
    logic [2*BW-1:0] fft_dout;
    logic            fft_done;
    logic            bin_valid;
    logic [2*BW-1:0] bin_data;
    logic [N-2:0]    bin_idx;
    logic            bin_last;
    logic            bin_ready;
    logic            busy;
    logic            overrun;
    logic            timeout_err;
    logic [2:0]      dbg_state;

    int total = 0;
    int bad   = 0;

    // Sticky flags as the frame-level model sees them.
    bit ovr_m   = 0;
    bit tmo_m   = 0;
    bit done_en = 1;

    fft_frame_ctrl #(.BIT_WIDTH(BW), .N(N), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .run(run),
        .smp_valid(smp_valid), .smp_data(smp_data), .smp_ready(smp_ready),
        .fft_load(fft_load), .fft_start(fft_start), .add_rd(add_rd), .din(din),
        .fft_dout(fft_dout), .fft_done(fft_done),
        .bin_valid(bin_valid), .bin_data(bin_data), .bin_idx(bin_idx),
        .bin_last(bin_last), .bin_ready(bin_ready),
        .busy(busy), .overrun(overrun), .timeout_err(timeout_err),
        .dbg_state(dbg_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stand-in: registered read {addr, ~addr}, done 20 cycles after start.
    logic [N-1:0] last_addr;
    int dly;
    initial begin
        fft_dout  = '0;
        fft_done  = 1'b0;
        last_addr = '0;
        dly       = 0;
        forever begin
            @(posedge clk);
            #1;
            fft_dout  = {16'(last_addr), ~16'(last_addr)};
            last_addr = add_rd;
            if (reset) dly = 0;
            else if (fft_start) dly = 1;
            else if (dly != 0 && dly < 40) dly++;
            fft_done = done_en && (dly == 20);
        end
    end

    function automatic logic [2*BW-1:0] bin_exp(input int b);
        logic [BW-1:0] a;
        a = BW'(b);
        return {a, ~a};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_smp_ready"}, smp_ready, 0);
        check({pfx, "_fft_load"}, fft_load, 0);
        check({pfx, "_fft_start"}, fft_start, 0);
        check({pfx, "_add_rd"}, add_rd, 0);
        check({pfx, "_din"}, din, 0);
        check({pfx, "_bin_valid"}, bin_valid, 0);
        check({pfx, "_bin_data"}, bin_data, 0);
        check({pfx, "_bin_idx"}, bin_idx, 0);
        check({pfx, "_bin_last"}, bin_last, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_overrun"}, overrun, 0);
        check({pfx, "_timeout_err"}, timeout_err, 0);
    endtask

    // Drive one frame. Called at a negedge with the DUT in IDLE (from_idle)
    // or LOAD. Returns at the negedge of the second WAIT cycle, or one cycle
    // after reset when abort_at >= 0.
    task automatic load_frame(input bit from_idle, input bit ramp, input bit all_valid,
                              input bit ovr, input int abort_at);
        int n = 0;
        bit ph = 0;
        logic [N-1:0] pa = '0;
        logic [BW-1:0] pd = '0;
        logic [BW-1:0] d;
        bit v;
        if (from_idle) begin
            run = 1'b1;
            smp_valid = 1'b0;
            @(negedge clk);
        end
        while (n < NSMP) begin
            if (n == abort_at) begin
                reset = 1'b1;
                run = 1'b0;
                smp_valid = 1'b1;
                @(negedge clk);
                ovr_m = 0;
                tmo_m = 0;
                check_zero("abort");
                reset = 1'b0;
                smp_valid = 1'b0;
                @(negedge clk);
                check("abort_after_load", fft_load, 0);
                check("abort_after_start", fft_start, 0);
                check("abort_after_busy", busy, 0);
                return;
            end
            check("load_smp_ready", smp_ready, 1);
            check("load_fft_start", fft_start, 0);
            check("load_fft_load", fft_load, ph);
            if (ph) begin
                check("load_add_rd", add_rd, pa);
                check("load_din", din, pd);
            end
            v = all_valid ? 1'b1 : 1'($urandom_range(0, 1));
            d = ramp ? BW'(n) : BW'($urandom);
            smp_valid = v;
            smp_data = d;
            ph = v;
            pa = N'(n);
            pd = d;
            if (v) n++;
            @(negedge clk);
        end
        // START cycle: the final load strobe is on the core port now.
        check("start_smp_ready", smp_ready, 0);
        check("start_fft_load", fft_load, 1);
        check("start_add_rd", add_rd, NSMP - 1);
        check("start_din", din, pd);
        check("start_fft_start", fft_start, 0);
        check("start_busy", busy, 1);
        smp_valid = ovr;
        @(negedge clk);
        if (ovr) ovr_m = 1;
        check("wait1_fft_start", fft_start, 1);
        check("wait1_fft_load", fft_load, 0);
        check("wait1_overrun", overrun, ovr_m);
        @(negedge clk);
        smp_valid = 1'b0;
        check("wait2_fft_start", fft_start, 0);
        check("wait2_overrun", overrun, ovr_m);
    endtask

    // Read out all bins with ready high pct percent of the time.
    task automatic read_frame(input int pct, input bit run_after);
        int w = 0;
        int tries;
        bit r;
        run = run_after;
        while (fft_done !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) begin
            check("fft_done_wait_expired", 0, 1);
            return;
        end
        check("wait_busy", busy, 1);
        @(negedge clk);
        for (int b = 0; b < NBIN; b++) begin
            check("rdaddr_bin_valid", bin_valid, 0);
            check("rdaddr_bin_data", bin_data, 0);
            check("rdaddr_add_rd", add_rd, b);
            @(negedge clk);
            tries = 0;
            forever begin
                check("pres_bin_valid", bin_valid, 1);
                check("pres_bin_idx", bin_idx, b);
                check("pres_bin_data", bin_data, bin_exp(b));
                check("pres_bin_last", bin_last, b == NBIN - 1);
                check("pres_add_rd", add_rd, b);
                check("pres_smp_ready", smp_ready, 0);
                check("pres_fft_start", fft_start, 0);
                check("pres_overrun", overrun, ovr_m);
                r = ($urandom_range(0, 99) < pct) || (tries >= 20);
                tries++;
                bin_ready = r;
                @(negedge clk);
                bin_ready = 1'b0;
                if (r) break;
            end
        end
        check("end_bin_valid", bin_valid, 0);
        check("end_bin_last", bin_last, 0);
        check("end_busy", busy, run_after);
        check("end_smp_ready", smp_ready, run_after);
    endtask

    // Main sequence.
    initial begin
        reset = 1'b1;
        run = 1'b0;
        smp_valid = 1'b0;
        smp_data = '0;
        bin_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Ramp frame at full rate, consumer always ready, straight back to LOAD.
        load_frame(1, 1, 1, 0, -1);
        read_frame(100, 1);

        // Random frame, gaps in input, samples pushed during WAIT, backpressure.
        load_frame(0, 0, 0, 1, -1);
        read_frame(50, 1);

        // Reset in the middle of loading.
        load_frame(0, 1, 1, 0, 200);

        // Restart from address 0; core never finishes so WAIT times out.
        done_en = 0;
        load_frame(1, 1, 1, 0, -1);
        run = 1'b0;
        repeat (TMO - 2) @(negedge clk);
        check("tmo_busy_before", busy, 1);
        check("tmo_err_before", timeout_err, tmo_m);
        @(negedge clk);
        tmo_m = 1;
        check("tmo_busy_after", busy, 0);
        check("tmo_err_after", timeout_err, tmo_m);
        check("tmo_smp_ready", smp_ready, 0);
        done_en = 1;
        @(negedge clk);

        // Random frame, run dropped before the end: returns to IDLE.
        load_frame(1, 0, 0, 0, -1);
        read_frame(70, 0);
        @(negedge clk);
        check("final_busy", busy, 0);
        check("final_timeout_err", timeout_err, tmo_m);
        check("final_overrun", overrun, ovr_m);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Frame sequencer for the 512-point FFT core. It accepts a stream of 16-bit real audio samples, writes one frame into the core through the load port, and pulses `fft_start`. It then waits for `fft_done` and streams the first half-spectrum bins out over a valid/ready interface. It sits between the sample front end (ADC/I2S deserializer) and the spectrum consumer (magnitude/display logic).

## Interface
Parameters:
- `BIT_WIDTH`, 16: real sample width; complex bin width is 2*BIT_WIDTH.
- `N`, 9: log2 of FFT length (frame = 2^N samples).
- `TIMEOUT`, 65535: maximum cycles spent in WAIT before abort.

Ports:
- `clk`  in  1: single clock.
- `reset`  in  1: synchronous, active-high.
- `run`  in  1: level; enables frame capture.
- `smp_valid`  in  1: input sample valid.
- `smp_data`  in  BIT_WIDTH: input sample, two's complement.
- `smp_ready`  out  1: high only in LOAD.
- `fft_load`  out  1: core load strobe, registered.
- `fft_start`  out  1: one-cycle start pulse.
- `add_rd`  out  N: core sample/bin address, registered.
- `din`  out  BIT_WIDTH: core load data, registered.
- `fft_dout`  in  2*BIT_WIDTH: core result {real, imag}, valid 1 cycle after `add_rd`.
- `fft_done`  in  1: core completion.
- `bin_valid`  out  1: output bin valid.
- `bin_data`  out  2*BIT_WIDTH: bin {real, imag}.
- `bin_idx`  out  N-1: bin index.
- `bin_last`  out  1: high with bin 2^(N-1)-1.
- `bin_ready`  in  1: consumer ready.
- `busy`  out  1: state != IDLE.
- `overrun`  out  1: sticky; a sample was offered while `smp_ready`=0 and `run`=1.
- `timeout_err`  out  1: sticky; WAIT expired.

## Operation
- States: IDLE, LOAD, START, WAIT, RD_ADDR, RD_PRES.
- IDLE: `run`=1 -> LOAD, sample counter = 0.
- LOAD: `smp_ready`=1. Each handshake (`smp_valid` && `smp_ready`) registers `fft_load`=1, `add_rd`=counter, `din`=`smp_data` for exactly the next cycle. The counter then increments. The handshake with counter = 2^N-1 -> START.
- START: `fft_start`=1 for one cycle; `fft_load`=0. -> WAIT with timer cleared.
- WAIT: when `fft_done`=1 is sampled -> RD_ADDR with bin counter = 0. The timer reaching TIMEOUT -> IDLE and sets `timeout_err`.
- RD_ADDR: drive `add_rd`=bin counter (zero-extended) with `fft_load`=0. -> RD_PRES.
- RD_PRES: `add_rd` is held. `bin_valid`=1, `bin_data`=`fft_dout` (passthrough), `bin_idx`=counter, `bin_last`=(counter==2^(N-1)-1).
  - On `bin_ready`: not last -> counter+1, RD_ADDR.
  - On `bin_ready` with last: `run`=1 -> LOAD (counter = 0), otherwise -> IDLE.
- `bin_valid`, `bin_data`, `bin_idx` and `bin_last` must stay stable until accepted.
- Bins are delivered in natural order: 0..2^(N-1)-1, i.e. 256 bins.
- Deasserting `run` mid-frame does not abort the frame; it completes through readout, then goes to IDLE.
- `overrun` is set by any cycle with `run`=1, `smp_valid`=1 and `smp_ready`=0. Dropped samples are not buffered.
- `fft_done` outside WAIT is ignored.

## Timing
- Reset: state IDLE. All outputs 0: `smp_ready`, `fft_load`, `fft_start`, `add_rd`, `din`, `bin_*`, `busy`, `overrun`, `timeout_err`. Counters 0.
- Reset asserted mid-frame returns the block to IDLE on the next edge, with no further load or start strobes.
- Load write lags the handshake by 1 cycle. `fft_start` rises the cycle after the final `fft_load`.
- Minimum frame input: 2^N cycles when `smp_valid` is held high.
- Readout: 2 cycles per bin minimum (RD_ADDR + RD_PRES). The first `bin_valid` appears 2 cycles after `fft_done` is sampled.
- `bin_ready` held high: 512 cycles for 256 bins.
- `busy` is registered from state.

## Test plan
- Reset, then `run`=1 and 512 consecutive samples with value = index -> `fft_load` pulses with `add_rd` 0..511 and `din`=0..511. Exactly one `fft_start` follows the cycle after `add_rd`=511.
- Core model returns `fft_dout`={addr, ~addr} with `fft_done` 20 cycles after start; `bin_ready`=1 -> 256 bins, `bin_idx` 0..255, data matches, `bin_last` only on 255. Then back to LOAD.
- Random `bin_ready` backpressure (50%) -> data and index stay stable while not ready. No bins lost or duplicated.
- `smp_valid`=1 during WAIT -> `overrun`=1 and stays set. The next frame loads only after readout.
- `fft_done` never asserted, TIMEOUT=100 -> IDLE after 100 WAIT cycles and `timeout_err`=1. `run`=0 at frame end -> IDLE, `busy`=0.
- `reset` pulsed during LOAD at sample 200 -> all outputs 0 next cycle. A restart loads from `add_rd`=0.
